sumsq_accumulator: RTL and testbench

SUMSQ_ACCUMULATOR -- requirements
Module: sumsq_accumulator

---
 rtl/sumsq_accumulator.sv | 80 ++++++++
 tb/tb_sumsq_accumulator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumsq_accumulator.sv
// Frame accumulator for squared 5-bit samples.
// Sums N_SAMPLES accepted squares and holds the result until consumed.
module sumsq_accumulator #(
  parameter int N_SAMPLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  sq_in,
  input  logic        sq_valid,
  output logic        sq_ready,
  output logic [14:0] sum_out,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic [5:0]  sample_cnt,
  output logic        range_err
);

  localparam logic [5:0] LAST = 6'(N_SAMPLES);
  localparam logic [9:0] MAX_SQ = 10'd961;

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic        accept;
  logic        last_accept;
  logic        handshake;
  logic [14:0] acc;
  logic [14:0] acc_sum;
  logic [5:0]  cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sq_ready    = (state == ACC);
    accept      = sq_ready & sq_valid;
    acc_sum     = acc + {5'd0, sq_in};
    cnt_inc     = sample_cnt + 6'd1;
    last_accept = accept & (cnt_inc == LAST);
    handshake   = (state == HOLD) & sum_ready;
    unique case (state)
      ACC:  if (last_accept) state_nxt = HOLD;
      HOLD: if (sum_ready)   state_nxt = ACC;
    endcase
  end

  // Accumulator is cleared only by the handshake, so HOLD keeps the count stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      sample_cnt <= '0;
      sum_out    <= '0;
      sum_valid  <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      if (accept) begin
        acc        <= acc_sum;
        sample_cnt <= cnt_inc;
        if (sq_in > MAX_SQ) range_err <= 1'b1;
        if (last_accept) begin
          sum_out   <= acc_sum;
          sum_valid <= 1'b1;
        end
      end
      if (handshake) begin
        acc        <= '0;
        sample_cnt <= '0;
        sum_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sumsq_accumulator.sv
// Scoreboard bench for sumsq_accumulator at N_SAMPLES = 8, 32 and 1.
// Frame sums are queued at stimulus time and checked by per-DUT monitors.
module tb_sumsq_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // DUT a: N=8, DUT b: N=32, DUT c: N=1
  logic        rst_a, rst_b;
  logic [9:0]  sq_in_a, sq_in_b, sq_in_c;
  logic        sq_valid_a, sq_valid_b, sq_valid_c;
  logic        sq_ready_a, sq_ready_b, sq_ready_c;
  logic [14:0] sum_out_a, sum_out_b, sum_out_c;
  logic        sum_valid_a, sum_valid_b, sum_valid_c;
  logic        sum_ready_a, sum_ready_b, sum_ready_c;
  logic [5:0]  cnt_a, cnt_b, cnt_c;
  logic        rerr_a, rerr_b, rerr_c;

  sumsq_accumulator #(.N_SAMPLES(8)) dut_a (
    .clk(clk), .rst(rst_a),
    .sq_in(sq_in_a), .sq_valid(sq_valid_a), .sq_ready(sq_ready_a),
    .sum_out(sum_out_a), .sum_valid(sum_valid_a), .sum_ready(sum_ready_a),
    .sample_cnt(cnt_a), .range_err(rerr_a)
  );

  sumsq_accumulator #(.N_SAMPLES(32)) dut_b (
    .clk(clk), .rst(rst_b),
    .sq_in(sq_in_b), .sq_valid(sq_valid_b), .sq_ready(sq_ready_b),
    .sum_out(sum_out_b), .sum_valid(sum_valid_b), .sum_ready(sum_ready_b),
    .sample_cnt(cnt_b), .range_err(rerr_b)
  );

  sumsq_accumulator #(.N_SAMPLES(1)) dut_c (
    .clk(clk), .rst(rst_b),
    .sq_in(sq_in_c), .sq_valid(sq_valid_c), .sq_ready(sq_ready_c),
    .sum_out(sum_out_c), .sum_valid(sum_valid_c), .sum_ready(sum_ready_c),
    .sample_cnt(cnt_c), .range_err(rerr_c)
  );

  int q_a[$];
  int q_b[$];
  int q_c[$];

  logic pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;

  always @(negedge clk) begin
    if (sum_valid_a && !pv_a) begin
      if (q_a.size() == 0) chk("a_unexpected_frame", 1, 0);
      else chk("a_sum_out", int'(sum_out_a), q_a.pop_front());
    end
    pv_a <= sum_valid_a;
  end

  always @(negedge clk) begin
    if (sum_valid_b && !pv_b) begin
      if (q_b.size() == 0) chk("b_unexpected_frame", 1, 0);
      else chk("b_sum_out", int'(sum_out_b), q_b.pop_front());
    end
    pv_b <= sum_valid_b;
  end

  always @(negedge clk) begin
    if (sum_valid_c && !pv_c) begin
      if (q_c.size() == 0) chk("c_unexpected_frame", 1, 0);
      else chk("c_sum_out", int'(sum_out_c), q_c.pop_front());
    end
    pv_c <= sum_valid_c;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic hs_a();
    @(negedge clk);
    sum_ready_a = 1'b1;
    @(posedge clk);
    #1 sum_ready_a = 1'b0;
  endtask

  task automatic hs_b();
    @(negedge clk);
    sum_ready_b = 1'b1;
    @(posedge clk);
    #1 sum_ready_b = 1'b0;
  endtask

  int vec8[8] = '{0, 1, 4, 9, 16, 25, 36, 49};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    sq_in_a = '0; sq_in_b = '0; sq_in_c = '0;
    sq_valid_a = 0; sq_valid_b = 0; sq_valid_c = 0;
    sum_ready_a = 0; sum_ready_b = 0; sum_ready_c = 0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;

    @(negedge clk);
    chk("rst_sq_ready", sq_ready_a, 1);
    chk("rst_sum_valid", sum_valid_a, 0);
    chk("rst_sum_out", int'(sum_out_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_range_err", rerr_a, 0);

    // back-to-back ramp of squares
    q_a.push_back(140);
    foreach (vec8[i]) begin
      sq_in_a = 10'(vec8[i]);
      sq_valid_a = 1'b1;
      @(posedge clk);
      #1;
    end
    sq_valid_a = 1'b0;
    @(negedge clk);
    chk("ramp_sum_valid", sum_valid_a, 1);
    chk("ramp_sq_ready", sq_ready_a, 0);
    chk("ramp_cnt", int'(cnt_a), 8);

    // stall in HOLD with sq_valid toggling
    for (int i = 0; i < 5; i++) begin
      sq_valid_a = (i % 2 == 0);
      sq_in_a = 10'd100;
      @(negedge clk);
      chk("hold_sum_out", int'(sum_out_a), 140);
      chk("hold_sum_valid", sum_valid_a, 1);
      chk("hold_cnt", int'(cnt_a), 8);
    end
    sum_ready_a = 1'b1;
    sq_valid_a = 1'b1;
    sq_in_a = 10'd7;
    @(posedge clk);
    #1 sum_ready_a = 1'b0;
    sq_valid_a = 1'b0;
    @(negedge clk);
    chk("hs_sum_valid", sum_valid_a, 0);
    chk("hs_cnt", int'(cnt_a), 0);
    chk("hs_sq_ready", sq_ready_a, 1);
    chk("hs_sum_out_kept", int'(sum_out_a), 140);

    // gapped valid
    q_a.push_back(32);
    for (int i = 0; i < 8; i++) begin
      sq_valid_a = 1'b1;
      sq_in_a = 10'd4;
      @(posedge clk);
      #1 sq_valid_a = 1'b0;
      @(negedge clk);
      chk("gap_cnt_acc", int'(cnt_a), i + 1);
      if (i < 7) begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("gap_cnt_idle", int'(cnt_a), i + 1);
      end
    end
    hs_a();

    // async reset after 5 accepts
    for (int i = 0; i < 5; i++) begin
      sq_valid_a = 1'b1;
      sq_in_a = 10'd10;
      @(posedge clk);
      #1;
    end
    sq_valid_a = 1'b0;
    @(negedge clk);
    chk("pre_rst_cnt", int'(cnt_a), 5);
    #2 rst_a = 1'b1;
    #1;
    chk("arst_cnt", int'(cnt_a), 0);
    chk("arst_sum_out", int'(sum_out_a), 0);
    chk("arst_sum_valid", sum_valid_a, 0);
    chk("arst_sq_ready", sq_ready_a, 1);
    sq_valid_a = 1'b1;
    sq_in_a = 10'd3;
    #1 rst_a = 1'b0;
    q_a.push_back(24);
    @(posedge clk);
    #1;
    chk("post_rst_first_accept", int'(cnt_a), 1);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    sq_valid_a = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", sum_valid_a, 1);
    chk("post_rst_range_err", rerr_a, 0);
    hs_a();

    // N=32 max legal values
    q_b.push_back(30752);
    repeat (32) begin
      sq_valid_b = 1'b1;
      sq_in_b = 10'd961;
      @(posedge clk);
      #1;
    end
    sq_valid_b = 1'b0;
    @(negedge clk);
    chk("b32_valid", sum_valid_b, 1);
    chk("b32_range_err", rerr_b, 0);
    hs_b();

    q_b.push_back(1023);
    sq_valid_b = 1'b1;
    sq_in_b = 10'd1023;
    @(posedge clk);
    #1 sq_in_b = 10'd0;
    @(negedge clk);
    chk("b_range_err_set", rerr_b, 1);
    repeat (31) begin
      @(posedge clk);
      #1;
    end
    sq_valid_b = 1'b0;
    @(negedge clk);
    chk("b_frame2_valid", sum_valid_b, 1);
    hs_b();
    @(negedge clk);
    chk("b_range_err_sticky", rerr_b, 1);

    // N=1 with sum_ready held high
    sum_ready_c = 1'b1;
    q_c.push_back(225);
    sq_valid_c = 1'b1;
    sq_in_c = 10'd225;
    @(posedge clk);
    #1 sq_valid_c = 1'b0;
    @(negedge clk);
    chk("c_valid_pulse", sum_valid_c, 1);
    chk("c_sq_ready_low", sq_ready_c, 0);
    chk("c_cnt", int'(cnt_c), 1);
    @(negedge clk);
    chk("c_valid_drop", sum_valid_c, 0);
    chk("c_sq_ready_back", sq_ready_c, 1);
    chk("c_sum_out_kept", int'(sum_out_c), 225);
    sum_ready_c = 1'b0;

    @(negedge clk);
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    chk("q_c_drained", q_c.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
